// File: rtl/y86_pipe_ctrl.sv
// Y86-64 five-stage pipeline control: combinational stall/bubble generation,
// idle/run/halted sequencing, and saturating hazard statistics counters.
module y86_pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             running,
    output logic             halted,
    output logic [3:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] ST_HLT    = 4'h2;
    localparam logic [3:0] ST_ADR    = 4'h3;
    localparam logic [3:0] ST_INS    = 4'h4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       halt_stat_q, halt_stat_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

    logic lu, mp, rt, mx, wx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic is_exc(input logic [3:0] s);
        return (s == ST_HLT) || (s == ST_ADR) || (s == ST_INS);
    endfunction

    // Hazard detection terms from in-flight instruction fields
    always_comb begin
        lu = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) &&
             (E_dstM != REG_NONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp = (E_icode == IC_JXX) && !e_Cnd;
        rt = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
        mx = is_exc(m_stat);
        wx = is_exc(W_stat);
    end

    // Next state, halt status capture and Mealy pipeline controls
    always_comb begin
        state_d     = state_q;
        halt_stat_d = halt_stat_q;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        W_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        set_cc      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                F_stall  = 1'b1;
                W_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (rt & !lu);
                E_bubble = mp | lu;
                M_bubble = mx | wx;
                W_stall  = wx;
                set_cc   = !(mx | wx);
                if (wx) begin
                    state_d     = S_HALTED;
                    halt_stat_d = W_stat;
                end
            end
            S_HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating statistics, advancing only on RUN cycles
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        lu_cnt_d  = lu_cnt_q;
        mp_cnt_d  = mp_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (state_q == S_RUN) begin
            cyc_cnt_d = sat_inc(cyc_cnt_q);
            if (lu) begin
                lu_cnt_d = sat_inc(lu_cnt_q);
            end
            if (mp) begin
                mp_cnt_d = sat_inc(mp_cnt_q);
            end
            if (rt && !lu && !mp) begin
                ret_cnt_d = sat_inc(ret_cnt_q);
            end
        end
    end

    // State and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            halt_stat_q <= 4'h0;
            cyc_cnt_q   <= '0;
            lu_cnt_q    <= '0;
            mp_cnt_q    <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_stat_q <= halt_stat_d;
            cyc_cnt_q   <= cyc_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign running   = (state_q == S_RUN);
    assign halted    = (state_q == S_HALTED);
    assign halt_stat = halt_stat_q;
    assign cyc_cnt   = cyc_cnt_q;
    assign lu_cnt    = lu_cnt_q;
    assign mp_cnt    = mp_cnt_q;
    assign ret_cnt   = ret_cnt_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Bench for y86_pipe_ctrl: table of RUN-cycle vectors with a scoreboard queue
// of expected controls, plus hand sequences for halt, restart and reset.
module tb_y86_pipe_ctrl;

    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    D_icode, E_icode, M_icode;
    logic [3:0]    d_srcA, d_srcB, E_dstM;
    logic          e_Cnd;
    logic [3:0]    m_stat, W_stat;
    logic          F_stall, D_stall, W_stall;
    logic          D_bubble, E_bubble, M_bubble;
    logic          set_cc, running, halted;
    logic [3:0]    halt_stat;
    logic [CW-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    y86_pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .running(running), .halted(halted),
        .halt_stat(halt_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: F_stall D_stall W_stall D_bubble E_bubble M_bubble set_cc
    typedef struct {
        string      name;
        logic [3:0] di, ei, mi, sa, sb, edm;
        logic       cnd;
        logic [3:0] ms, ws;
        logic [6:0] ctl;
        logic       ilu, imp, irt;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic       run;
        logic       hlt;
    } exp_t;

    localparam logic [6:0] CTL_IDLE   = 7'b1011110;
    localparam logic [6:0] CTL_HALTED = 7'b1110000;

    vec_t tv[16];
    exp_t sbq[$];
    int   checks, errors;
    int   m_cyc, m_lu, m_mp, m_rt;

    function automatic vec_t mk(input string nm,
                                input logic [3:0] di, input logic [3:0] ei, input logic [3:0] mi,
                                input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] edm,
                                input logic cnd, input logic [3:0] ms, input logic [3:0] ws,
                                input logic [6:0] ctl, input logic ilu, input logic imp,
                                input logic irt);
        vec_t v;
        v.name = nm; v.di = di; v.ei = ei; v.mi = mi; v.sa = sa; v.sb = sb;
        v.edm = edm; v.cnd = cnd; v.ms = ms; v.ws = ws; v.ctl = ctl;
        v.ilu = ilu; v.imp = imp; v.irt = irt;
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic quiet();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1;
    endtask

    task automatic drive(input vec_t v);
        D_icode = v.di; E_icode = v.ei; M_icode = v.mi;
        d_srcA = v.sa; d_srcB = v.sb; E_dstM = v.edm;
        e_Cnd = v.cnd; m_stat = v.ms; W_stat = v.ws;
    endtask

    task automatic push(input string nm, input logic [6:0] ctl, input logic run, input logic hlt);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.run = run; e.hlt = hlt;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        logic [6:0] act;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, expected an entry at %0t", $time);
            return;
        end
        e = sbq.pop_front();
        act = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};
        chk({e.name, ".ctl"}, 32'(act), 32'(e.ctl));
        chk({e.name, ".running"}, 32'(running), 32'(e.run));
        chk({e.name, ".halted"}, 32'(halted), 32'(e.hlt));
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, ".cyc_cnt"}, 32'(cyc_cnt), 32'(m_cyc));
        chk({tag, ".lu_cnt"},  32'(lu_cnt),  32'(m_lu));
        chk({tag, ".mp_cnt"},  32'(mp_cnt),  32'(m_mp));
        chk({tag, ".ret_cnt"}, 32'(ret_cnt), 32'(m_rt));
    endtask

    initial begin
        checks = 0; errors = 0;
        m_cyc = 0; m_lu = 0; m_mp = 0; m_rt = 0;

        //          name         D    E    M    sA   sB   dstM cnd ms   ws   F D W Db Eb Mb cc   lu mp rt
        tv[0]  = mk("quiet",     4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b0000001, 0,0,0);
        tv[1]  = mk("lu_mrmov",  4'h1,4'h5,4'h1,4'h3,4'hF,4'h3,1, 4'h1,4'h1,7'b1100101, 1,0,0);
        tv[2]  = mk("no_lu_f",   4'h1,4'h5,4'h1,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b0000001, 0,0,0);
        tv[3]  = mk("lu_popq",   4'h1,4'hB,4'h1,4'hF,4'h4,4'h4,1, 4'h1,4'h1,7'b1100101, 1,0,0);
        tv[4]  = mk("no_lu_reg", 4'h1,4'h5,4'h1,4'h2,4'h4,4'h3,1, 4'h1,4'h1,7'b0000001, 0,0,0);
        tv[5]  = mk("mispred",   4'h1,4'h7,4'h1,4'hF,4'hF,4'hF,0, 4'h1,4'h1,7'b0001101, 0,1,0);
        tv[6]  = mk("jxx_taken", 4'h1,4'h7,4'h1,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b0000001, 0,0,0);
        tv[7]  = mk("ret_d",     4'h9,4'h1,4'h1,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b1001001, 0,0,1);
        tv[8]  = mk("ret_e",     4'h1,4'h9,4'h1,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b1001001, 0,0,1);
        tv[9]  = mk("ret_m",     4'h1,4'h1,4'h9,4'hF,4'hF,4'hF,1, 4'h1,4'h1,7'b1001001, 0,0,1);
        tv[10] = mk("ret_mp",    4'h9,4'h7,4'h1,4'hF,4'hF,4'hF,0, 4'h1,4'h1,7'b1001101, 0,1,0);
        tv[11] = mk("ret_lu",    4'h9,4'hB,4'h1,4'hF,4'h4,4'h4,1, 4'h1,4'h1,7'b1100101, 1,0,0);
        tv[12] = mk("m_ins",     4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1, 4'h4,4'h1,7'b0000010, 0,0,0);
        tv[13] = mk("m_hlt_mp",  4'h1,4'h7,4'h1,4'hF,4'hF,4'hF,0, 4'h2,4'h1,7'b0001110, 0,1,0);
        tv[14] = mk("m_adr",     4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1, 4'h3,4'h1,7'b0000010, 0,0,0);
        tv[15] = mk("w_adr_lu",  4'h1,4'h5,4'h1,4'h3,4'hF,4'h3,1, 4'h1,4'h3,7'b1110110, 1,0,0);

        quiet();
        start = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        push("reset", CTL_IDLE, 1'b0, 1'b0);
        pop_check();
        chk("reset.halt_stat", 32'(halt_stat), 32'h0);
        chk_cnts("reset");

        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        push("idle_start", CTL_IDLE, 1'b0, 1'b0);
        @(negedge clk);
        pop_check();
        @(posedge clk); #1 start = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i]);
            push(tv[i].name, tv[i].ctl, 1'b1, 1'b0);
            @(negedge clk);
            pop_check();
            chk_cnts(tv[i].name);
            m_cyc = sat(m_cyc);
            if (tv[i].ilu) m_lu = sat(m_lu);
            if (tv[i].imp) m_mp = sat(m_mp);
            if (tv[i].irt) m_rt = sat(m_rt);
            @(posedge clk); #1;
        end

        // Halt reached on the W exception edge; last RUN cycle still counted
        quiet();
        push("halted", CTL_HALTED, 1'b0, 1'b1);
        @(negedge clk);
        pop_check();
        chk("halted.halt_stat", 32'(halt_stat), 32'h3);
        chk_cnts("halted");
        chk("sat.cyc_cnt", 32'(cyc_cnt), 32'(CMAX));

        // start is ignored once halted
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drive(tv[1]);
        push("halt_start", CTL_HALTED, 1'b0, 1'b1);
        @(negedge clk);
        pop_check();
        chk("halt_start.halt_stat", 32'(halt_stat), 32'h3);
        @(posedge clk); #1;
        chk_cnts("halt_hold");

        // Reset from HALTED, then run 10 cycles and reset between edges
        quiet();
        rst_n = 1'b0;
        m_cyc = 0; m_lu = 0; m_mp = 0; m_rt = 0;
        #1;
        push("rst_halt", CTL_IDLE, 1'b0, 1'b0);
        pop_check();
        chk("rst_halt.halt_stat", 32'(halt_stat), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("midrun.cyc_cnt", 32'(cyc_cnt), 32'd10);
        chk("midrun.running", 32'(running), 32'h1);
        rst_n = 1'b0;
        #1;
        push("rst_midrun", CTL_IDLE, 1'b0, 1'b0);
        pop_check();
        chk_cnts("rst_midrun");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        push("post_rst", CTL_IDLE, 1'b0, 1'b0);
        pop_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
